// File: rtl/otsr_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | otsr_sched: tile scheduler and port arbiter for the output SRAM (otsr) |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module otsr_sched #(
    parameter int NUM_TILES      = 4,
    parameter int TILE_BITS      = 8,
    parameter int SRAM_ADDR_BITS = 10,
    parameter int SRAM_DATA_BITS = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      all_done,
    output logic [TILE_BITS-1:0]      tile_cnt,
    output logic                      err_conflict,
    input  logic                      cmp_cen,
    input  logic                      cmp_wen,
    input  logic [SRAM_ADDR_BITS-1:0] cmp_addr,
    input  logic [SRAM_DATA_BITS-1:0] cmp_data,
    input  logic                      cmp_done,
    output logic                      cmp_hold,
    output logic                      rd_start,
    input  logic                      rd_done,
    input  logic                      rd_cen,
    input  logic [SRAM_ADDR_BITS-1:0] rd_addr,
    output logic                      cen_otsr,
    output logic                      wen_otsr,
    output logic [SRAM_ADDR_BITS-1:0] addr_otsr,
    output logic [SRAM_DATA_BITS-1:0] data_otsr
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CMP = 3'd1,
        S_KICK     = 3'd2,
        S_READ     = 3'd3,
        S_NEXT     = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam logic [TILE_BITS-1:0] c_LAST_TILE = TILE_BITS'(NUM_TILES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TILE_BITS-1:0] r_tile_cnt;
    logic                 r_pend_done;
    logic                 r_err_conflict;
    logic                 w_start_ok;
    logic                 w_last_tile;
    logic                 w_conflict;
    logic                 w_pend_set;
    logic                 w_pend_clr;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_last_tile = (r_tile_cnt == c_LAST_TILE);
    assign w_conflict  = (r_state != S_WAIT_CMP) && !cmp_cen;
    assign w_pend_set  = cmp_done &&
                         ((r_state == S_KICK) || (r_state == S_READ) || (r_state == S_NEXT));
    assign w_pend_clr  = w_start_ok || ((r_state == S_NEXT) && (w_state_nxt == S_KICK));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start)    w_state_nxt = S_WAIT_CMP;
            S_WAIT_CMP: if (cmp_done) w_state_nxt = S_KICK;
            S_KICK:                   w_state_nxt = S_READ;
            S_READ:     if (rd_done)  w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (w_last_tile)      w_state_nxt = S_FINISH;
                else if (r_pend_done) w_state_nxt = S_KICK;
                else                  w_state_nxt = S_WAIT_CMP;
            end
            S_FINISH:                 w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // A done arriving while the previous tile drains wins over the clear on NEXT->KICK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_tile_cnt     <= '0;
            r_pend_done    <= 1'b0;
            r_err_conflict <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok)
                r_tile_cnt <= '0;
            else if (r_state == S_NEXT)
                r_tile_cnt <= r_tile_cnt + TILE_BITS'(1);
            if (w_pend_set)
                r_pend_done <= 1'b1;
            else if (w_pend_clr)
                r_pend_done <= 1'b0;
            if (w_conflict)
                r_err_conflict <= 1'b1;
            else if (w_start_ok)
                r_err_conflict <= 1'b0;
        end
    end

    // Port mux: compute only in WAIT_CMP, reader only in KICK/READ, otherwise idle.
    always_comb begin
        cen_otsr  = 1'b1;
        wen_otsr  = 1'b1;
        addr_otsr = '0;
        data_otsr = '0;
        case (r_state)
            S_WAIT_CMP: begin
                cen_otsr  = cmp_cen;
                wen_otsr  = cmp_wen;
                addr_otsr = cmp_addr;
                data_otsr = cmp_data;
            end
            S_KICK, S_READ: begin
                cen_otsr  = rd_cen;
                addr_otsr = rd_addr;
            end
            default: ;
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign all_done     = (r_state == S_FINISH);
    assign tile_cnt     = r_tile_cnt;
    assign err_conflict = r_err_conflict;
    assign cmp_hold     = (r_state != S_WAIT_CMP);
    assign rd_start     = (r_state == S_KICK);

endmodule
`default_nettype wire

// File: tb/tb_otsr_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_otsr_sched: vector table, directed sequences and random run of      |
// | otsr_sched against a per-cycle reference model. Revision: 1.0          |
// +------------------------------------------------------------------------+
module tb_otsr_sched;
    localparam int NT = 2;
    localparam int TB = 8;
    localparam int AB = 10;
    localparam int DB = 64;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_KICK = 2;
    localparam int P_READ = 3;
    localparam int P_NEXT = 4;
    localparam int P_FIN  = 5;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          cmp_cen  = 1'b1;
    logic          cmp_wen  = 1'b1;
    logic [AB-1:0] cmp_addr = '0;
    logic [DB-1:0] cmp_data = '0;
    logic          cmp_done = 1'b0;
    logic          rd_done  = 1'b0;
    logic          rd_cen   = 1'b1;
    logic [AB-1:0] rd_addr  = '0;

    logic          busy, all_done, err_conflict, cmp_hold, rd_start, cen_otsr, wen_otsr;
    logic [TB-1:0] tile_cnt;
    logic [AB-1:0] addr_otsr;
    logic [DB-1:0] data_otsr;

    logic          u1_busy, u1_all_done, u1_err_conflict, u1_cmp_hold, u1_rd_start;
    logic          u1_cen_otsr, u1_wen_otsr;
    logic [TB-1:0] u1_tile_cnt;
    logic [AB-1:0] u1_addr_otsr;
    logic [DB-1:0] u1_data_otsr;

    int checks   = 0;
    int failures = 0;

    otsr_sched #(.NUM_TILES(NT), .TILE_BITS(TB), .SRAM_ADDR_BITS(AB), .SRAM_DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .all_done(all_done),
        .tile_cnt(tile_cnt), .err_conflict(err_conflict), .cmp_cen(cmp_cen), .cmp_wen(cmp_wen),
        .cmp_addr(cmp_addr), .cmp_data(cmp_data), .cmp_done(cmp_done), .cmp_hold(cmp_hold),
        .rd_start(rd_start), .rd_done(rd_done), .rd_cen(rd_cen), .rd_addr(rd_addr),
        .cen_otsr(cen_otsr), .wen_otsr(wen_otsr), .addr_otsr(addr_otsr), .data_otsr(data_otsr)
    );

    otsr_sched #(.NUM_TILES(1), .TILE_BITS(TB), .SRAM_ADDR_BITS(AB), .SRAM_DATA_BITS(DB)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(u1_busy), .all_done(u1_all_done),
        .tile_cnt(u1_tile_cnt), .err_conflict(u1_err_conflict), .cmp_cen(cmp_cen), .cmp_wen(cmp_wen),
        .cmp_addr(cmp_addr), .cmp_data(cmp_data), .cmp_done(cmp_done), .cmp_hold(u1_cmp_hold),
        .rd_start(u1_rd_start), .rd_done(rd_done), .rd_cen(rd_cen), .rd_addr(rd_addr),
        .cen_otsr(u1_cen_otsr), .wen_otsr(u1_wen_otsr), .addr_otsr(u1_addr_otsr), .data_otsr(u1_data_otsr)
    );

    always #5 clk = ~clk;

    // Reference model of the main instance, phrased as run phases and counters.
    int m_phase = P_IDLE;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;
    bit m_err   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= P_IDLE;
            m_cnt   <= 0;
            m_pend  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase <= P_WAIT;
                    m_cnt   <= 0;
                    m_pend  <= 1'b0;
                    m_err   <= 1'b0;
                end
                P_WAIT: if (cmp_done) m_phase <= P_KICK;
                P_KICK: m_phase <= P_READ;
                P_READ: if (rd_done) m_phase <= P_NEXT;
                P_NEXT: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == NT) m_phase <= P_FIN;
                    else if (m_pend) begin
                        m_phase <= P_KICK;
                        m_pend  <= 1'b0;
                    end else m_phase <= P_WAIT;
                end
                default: m_phase <= P_IDLE;
            endcase
            if (cmp_done && m_phase >= P_KICK && m_phase <= P_NEXT) m_pend <= 1'b1;
            if (!cmp_cen && m_phase != P_WAIT) m_err <= 1'b1;
        end
    end

    function automatic logic [88:0] exp_vec();
        logic          c, w;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        c = 1'b1; w = 1'b1; a = '0; d = '0;
        if (m_phase == P_WAIT) begin
            c = cmp_cen; w = cmp_wen; a = cmp_addr; d = cmp_data;
        end else if (m_phase == P_KICK || m_phase == P_READ) begin
            c = rd_cen; a = rd_addr;
        end
        return {m_phase != P_IDLE, m_phase == P_FIN, TB'(m_cnt), m_err,
                m_phase != P_WAIT, m_phase == P_KICK, c, w, a, d};
    endfunction

    wire [88:0] act_vec = {busy, all_done, tile_cnt, err_conflict, cmp_hold, rd_start,
                           cen_otsr, wen_otsr, addr_otsr, data_otsr};

    always @(negedge clk) begin
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act_vec, exp_vec());
        end
    end

    bit mon_on = 1'b0;
    int n_rds  = 0;
    int n_ad   = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_start) n_rds++;
            if (all_done) n_ad++;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 1'b0; cmp_cen = 1'b1; cmp_wen = 1'b1; cmp_addr = '0; cmp_data = '0;
        cmp_done = 1'b0; rd_done = 1'b0; rd_cen = 1'b1; rd_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic          st, ccen, cwen, cdone, rdone, rcen;
        logic [AB-1:0] caddr, raddr;
        logic [DB-1:0] cdata;
        logic [88:0]   exp;
    } vec_t;

    function automatic vec_t mk(input int st, input int ccen, input int cwen, input int caddr,
                                input logic [DB-1:0] cdata, input int cdone, input int rdone,
                                input int rcen, input int raddr, input int bsy, input int ad,
                                input int cnt, input int err, input int hold, input int rds,
                                input int cen, input int wen, input int addr,
                                input logic [DB-1:0] data);
        vec_t v;
        v.st = st[0]; v.ccen = ccen[0]; v.cwen = cwen[0]; v.caddr = AB'(caddr);
        v.cdata = cdata; v.cdone = cdone[0]; v.rdone = rdone[0]; v.rcen = rcen[0];
        v.raddr = AB'(raddr);
        v.exp = {bsy[0], ad[0], TB'(cnt), err[0], hold[0], rds[0], cen[0], wen[0], AB'(addr), data};
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        //          st cc cw ca ---cdata--- cd rd rc ra | bsy ad cnt err hold rds cen wen addr --data--
        tbl[0]  = mk(0, 1, 1, 0, 64'h0,       0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[1]  = mk(1, 1, 1, 0, 64'h0,       0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[2]  = mk(0, 0, 0, 5, 64'hAA,      0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 5, 64'hAA);
        tbl[3]  = mk(0, 1, 1, 6, 64'hBB,      1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 6, 64'hBB);
        tbl[4]  = mk(0, 1, 1, 9, 64'hCC,      0, 0, 0, 3,  1, 0, 0, 0, 1, 1, 0, 1, 3, 64'h0);
        tbl[5]  = mk(1, 1, 1, 0, 64'h0,       0, 0, 0, 7,  1, 0, 0, 0, 1, 0, 0, 1, 7, 64'h0);
        tbl[6]  = mk(0, 1, 1, 0, 64'h0,       0, 1, 1, 8,  1, 0, 0, 0, 1, 0, 1, 1, 8, 64'h0);
        tbl[7]  = mk(0, 1, 1, 0, 64'h0,       0, 0, 0, 4,  1, 0, 0, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[8]  = mk(0, 1, 1, 2, 64'h0,       0, 1, 1, 0,  1, 0, 1, 0, 0, 0, 1, 1, 2, 64'h0);
        tbl[9]  = mk(0, 1, 1, 2, 64'h0,       1, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1, 1, 2, 64'h0);
        tbl[10] = mk(0, 1, 1, 0, 64'h0,       0, 0, 1, 0,  1, 0, 1, 0, 1, 1, 1, 1, 0, 64'h0);
        tbl[11] = mk(0, 1, 1, 0, 64'h0,       0, 1, 1, 0,  1, 0, 1, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[12] = mk(0, 1, 1, 0, 64'h0,       0, 0, 1, 0,  1, 0, 1, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[13] = mk(0, 1, 1, 0, 64'h0,       0, 0, 1, 0,  1, 1, 2, 0, 1, 0, 1, 1, 0, 64'h0);
        tbl[14] = mk(0, 1, 1, 0, 64'h0,       0, 0, 1, 0,  0, 0, 2, 0, 1, 0, 1, 1, 0, 64'h0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st; cmp_cen = tbl[i].ccen; cmp_wen = tbl[i].cwen;
            cmp_addr = tbl[i].caddr; cmp_data = tbl[i].cdata; cmp_done = tbl[i].cdone;
            rd_done = tbl[i].rdone; rd_cen = tbl[i].rcen; rd_addr = tbl[i].raddr;
            neg();
            chk($sformatf("tbl%0d", i), 96'(act_vec), 96'(tbl[i].exp));
            tick();
        end

        // Two full tiles: 20 compute writes each, reader done 25 cycles after its start.
        do_reset();
        mon_on = 1'b1; n_rds = 0; n_ad = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < NT; t++) begin
            for (int a = 0; a < 20; a++) begin
                cmp_cen = 1'b0; cmp_wen = 1'b0; cmp_addr = AB'(a); cmp_data = {$urandom, $urandom};
                neg();
                chk("t1_wr_addr", 96'(addr_otsr), 96'(a));
                tick();
            end
            cmp_cen = 1'b1; cmp_wen = 1'b1; cmp_done = 1'b1; tick(); cmp_done = 1'b0;
            neg();
            chk("t1_rd_start_latency", 96'(rd_start), 96'(1));
            repeat (25) tick();
            rd_done = 1'b1; tick(); rd_done = 1'b0;
            neg();
            chk("t1_next_hold", 96'(cmp_hold), 96'(1));
            if (t < NT - 1) begin
                tick(); neg();
                chk("t1_grant_latency", 96'(cmp_hold), 96'(0));
            end
        end
        tick(); neg();
        chk("t1_finish_all_done", 96'({busy, all_done}), 96'(2'b11));
        tick(); neg();
        chk("t1_idle_busy_cnt", 96'({busy, all_done, tile_cnt}), 96'({2'b00, TB'(NT)}));
        tick();
        mon_on = 1'b0;
        chk("t1_rd_start_count", 96'(n_rds), 96'(NT));
        chk("t1_all_done_count", 96'(n_ad), 96'(1));

        // Conflict during READ is dropped and sticky until the next accepted start.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        cmp_cen = 1'b0; rd_cen = 1'b1;
        neg();
        chk("t3_cen_follows_rd_hi", 96'(cen_otsr), 96'(1));
        rd_cen = 1'b0; #1;
        chk("t3_cen_follows_rd_lo", 96'(cen_otsr), 96'(0));
        tick();
        cmp_cen = 1'b1; rd_cen = 1'b1;
        neg();
        chk("t3_err_set", 96'(err_conflict), 96'(1));
        rd_done = 1'b1; tick(); rd_done = 1'b0; tick();
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0; tick(); tick();
        neg();
        chk("t3_err_sticky_idle", 96'({busy, err_conflict}), 96'(2'b01));
        start = 1'b1; tick(); start = 1'b0;
        neg();
        chk("t3_err_cleared_by_start", 96'(err_conflict), 96'(0));

        // Early cmp_done during READ sends NEXT straight to KICK.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        cmp_done = 1'b1; tick(); cmp_done = 1'b0;
        repeat (3) tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        neg();
        chk("t4_next_no_rd_start", 96'(rd_start), 96'(0));
        tick(); neg();
        chk("t4_kick_after_pend", 96'({rd_start, cmp_hold}), 96'(2'b11));
        tick(); rd_done = 1'b1; tick(); rd_done = 1'b0; tick();
        neg();
        chk("t4_finish", 96'({all_done, tile_cnt}), 96'({1'b1, TB'(2)}));
        tick();

        // Asynchronous reset in the middle of the second tile's READ.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0; tick();
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        cmp_cen = 1'b0; tick(); cmp_cen = 1'b1;
        rd_cen = 1'b0; rd_addr = AB'(7);
        neg();
        chk("t5_pre_reset", 96'({busy, tile_cnt, err_conflict, addr_otsr}), 96'({1'b1, TB'(1), 1'b1, AB'(7)}));
        #2 reset = 1'b1; #1;
        chk("t5_async_reset", 96'(act_vec), 96'({1'b0, 1'b0, TB'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, AB'(0), DB'(0)}));
        rd_cen = 1'b1; rd_addr = '0;
        start = 1'b1; tick(); start = 1'b0; reset = 1'b0;
        neg();
        chk("t5_start_during_reset_ignored", 96'(busy), 96'(0));
        tick();
        start = 1'b1; tick(); start = 1'b0;
        neg();
        chk("t5_fresh_run", 96'({busy, cmp_hold, tile_cnt}), 96'({2'b10, TB'(0)}));

        // Single-tile instance: FINISH directly after the first NEXT.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        cmp_done = 1'b1; tick(); cmp_done = 1'b0; tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        neg();
        chk("t6_n1_next", 96'({u1_busy, u1_all_done}), 96'(2'b10));
        tick(); neg();
        chk("t6_n1_finish", 96'({u1_all_done, u1_tile_cnt}), 96'({1'b1, TB'(1)}));
        tick(); neg();
        chk("t6_n1_idle", 96'(u1_busy), 96'(0));

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 9) == 0);
            cmp_done = (m_phase != P_NEXT) && ($urandom_range(0, 7) == 0);
            rd_done  = ($urandom_range(0, 5) == 0);
            rd_cen   = $urandom_range(0, 1) != 0;
            rd_addr  = AB'($urandom);
            cmp_wen  = $urandom_range(0, 1) != 0;
            cmp_addr = AB'($urandom);
            cmp_data = {$urandom, $urandom};
            if (m_phase == P_WAIT) cmp_cen = $urandom_range(0, 1) != 0;
            else if (m_phase == P_IDLE) cmp_cen = 1'b1;
            else cmp_cen = ($urandom_range(0, 39) != 0);
            reset = (i % 500 == 250);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
